// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-clock data memory controller for the core's load/store path.
// One request at a time over valid/ready; RISC-V funct3 loads/stores with
// byte-lane writes and sign/zero extension; configurable read latency (1..3).
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (flags req_addr >= DEPTH*4 as
// an error instead of letting upper address bits alias).
// Parameter constraints: DEPTH a power of two, >= 4; READ_LAT in 1..3;
// ADDR_W >= log2(DEPTH)+2.

module dmem_ctrl #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    // Counter value on which LOAD hands over to RESP; a latency of one skips LOAD.
    localparam logic [1:0] LOAD_LAST = 2'(READ_LAT - 1);
    localparam bit         LOAD_SKIP = (READ_LAT <= 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         cnt, cnt_nxt;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        rd_word;

    logic [2:0]         cap_memop;
    logic [1:0]         cap_lane;
    logic               cap_we;
    logic               cap_err;

    logic               accept;
    logic [IDX_W-1:0]   idx;
    logic               illegal_op;
    logic               misaligned;
    logic               out_of_range;
    logic               req_err;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_rep;
    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic [31:0]        load_ext;

    // Upper address bits are only consumed when the bounds check is built in.
    logic               unused_addr;
    assign unused_addr = ^req_addr;

    assign req_ready = (state == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign idx       = req_addr[IDX_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * 4);
    assign out_of_range = ({1'b0, req_addr} >= SPAN);
`else
    assign out_of_range = 1'b0;
`endif

    // Decode legality, alignment and store lane enables of the presented request.
    // NOTE: every output of an always_comb gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        illegal_op = 1'b0;
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        wdata_rep  = req_wdata;

        if (req_we) begin
            illegal_op = req_memop[2] | (req_memop[1:0] == 2'b11);
        end else begin
            illegal_op = (req_memop == 3'b011) | (req_memop == 3'b110) | (req_memop == 3'b111);
        end

        if (req_memop[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_memop[1:0] == 2'b10) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end

        case (req_memop[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                wdata_rep = req_wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = req_wdata;
            end
        endcase
    end

    assign req_err = illegal_op | misaligned | out_of_range;

    // FSM state and latency counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and response strobe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rsp_valid = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = 2'd0;
                if (accept) begin
                    if (req_we || req_err || LOAD_SKIP) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = LOAD;
                        cnt_nxt   = 2'd1;
                    end
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) begin
                    state_nxt = RESP;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Capture the request attributes needed for the response on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_memop <= 3'b000;
            cap_lane  <= 2'b00;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
        end else if (accept) begin
            cap_memop <= req_memop;
            cap_lane  <= req_addr[1:0];
            cap_we    <= req_we;
            cap_err   <= req_err;
        end
    end

    // Storage: read the addressed word and commit legal stores on the accept edge.
    // NOTE: the array and its read register are deliberately not reset so they map onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word <= mem[idx];
            if (req_we && !req_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                    end
                end
            end
        end
    end

    // Lane selection and sign/zero extension of the loaded word.
    always_comb begin
        sel_byte = rd_word[8*cap_lane +: 8];
        sel_half = cap_lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_ext = 32'd0;
        case (cap_memop)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_ext = rd_word;
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = 32'd0;
        endcase
    end

    // Response payload: data only for successful loads, zero otherwise.
    always_comb begin
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        if (state == RESP) begin
            rsp_err = cap_err;
            if (!cap_err && !cap_we) begin
                rsp_rdata = load_ext;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl. Two instances share one request
// bus: u_lat1 (READ_LAT=1) and u_lat3 (READ_LAT=3), so every transaction checks
// both the zero-cycle LOAD path and the counted LOAD path.

module tb_dmem_ctrl;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic        ready3, rsp_valid3, rsp_err3;
    logic [31:0] rsp_rdata3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(DEPTH), .READ_LAT(1), .ADDR_W(ADDR_W)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
        .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    dmem_ctrl #(.DEPTH(DEPTH), .READ_LAT(3), .ADDR_W(ADDR_W)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(ready3), .req_we(req_we),
        .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request presented for a single cycle from a negedge; both instances
    // are observed for six cycles after the accept edge.
    task automatic txn(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int          n1, n3, lat1, lat3, exp_lat3;
        logic [31:0] rd1, rd3, junk;
        logic        e1, e3;
        n1 = 0; n3 = 0; lat1 = 0; lat3 = 0;
        rd1 = 32'hx; rd3 = 32'hx; e1 = 1'bx; e3 = 1'bx;
        exp_lat3 = (!we && !exp_err) ? 3 : 1;

        check({tag, " ready1 idle"}, 32'(ready1), 32'd1);
        check({tag, " ready3 idle"}, 32'(ready3), 32'd1);
        req_we    = we;
        req_memop = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        // Scramble the bus: the controller must only use what it captured.
        req_valid = 1'b0;
        junk      = $urandom;
        req_we    = junk[0];
        req_memop = junk[3:1];
        req_addr  = $urandom;
        req_wdata = $urandom;
        check({tag, " ready1 busy"}, 32'(ready1), 32'd0);
        check({tag, " ready3 busy"}, 32'(ready3), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            if (rsp_valid1) begin n1++; lat1 = k; rd1 = rsp_rdata1; e1 = rsp_err1; end
            if (rsp_valid3) begin n3++; lat3 = k; rd3 = rsp_rdata3; e3 = rsp_err3; end
            @(negedge clk);
        end
        check({tag, " pulses1"}, 32'(n1), 32'd1);
        check({tag, " pulses3"}, 32'(n3), 32'd1);
        check({tag, " lat1"}, 32'(lat1), 32'd1);
        check({tag, " lat3"}, 32'(lat3), 32'(exp_lat3));
        check({tag, " rdata1"}, rd1, exp_rd);
        check({tag, " rdata3"}, rd3, exp_rd);
        check({tag, " err1"}, 32'(e1), 32'(exp_err));
        check({tag, " err3"}, 32'(e3), 32'(exp_err));
    endtask

    initial begin
        logic [4:0] r1_pat, v1_pat, r3_pat, v3_pat;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_memop = 3'b000;
        req_addr  = 32'd0;
        req_wdata = 32'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst ready1", 32'(ready1), 32'd0);
        check("rst ready3", 32'(ready3), 32'd0);
        check("rst valid1", 32'(rsp_valid1), 32'd0);
        check("rst valid3", 32'(rsp_valid3), 32'd0);
        check("rst rdata3", rsp_rdata3, 32'd0);
        check("rst err3", 32'(rsp_err3), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store then word load.
        txn("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store into a known word, then byte/half loads.
        txn("sw10b", 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0);
        txn("sb13",  1'b1, 3'b000, 32'h13, 32'hFFFFFF80, 32'h0, 1'b0);
        txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80223344, 1'b0);
        txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        txn("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 32'h00000044, 1'b0);
        txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8022, 1'b0);
        txn("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h00003344, 1'b0);

        // Halfword store into an upper lane pair.
        txn("sw20",  1'b1, 3'b010, 32'h20, 32'h00000000, 32'h0, 1'b0);
        txn("sh22",  1'b1, 3'b001, 32'h22, 32'hABCD8001, 32'h0, 1'b0);
        txn("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0);
        txn("lh22",  1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        txn("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);

        // Errors: misaligned and illegal memops respond at N+1 with rdata 0.
        txn("lw21",  1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1);
        txn("sh23",  1'b1, 3'b001, 32'h23, 32'h0000FFFF, 32'h0, 1'b1);
        txn("sw22",  1'b1, 3'b010, 32'h22, 32'h12345678, 32'h0, 1'b1);
        txn("ld011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
        txn("lh21",  1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
        txn("st011", 1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("st100", 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("lw20e", 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0);

        // req_valid held high: ready/valid cadence per instance over cycles N..N+4.
        r1_pat = 5'b10101; v1_pat = 5'b01010;
        r3_pat = 5'b10001; v3_pat = 5'b01000;
        req_we    = 1'b0;
        req_memop = 3'b010;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("hold ready1 c%0d", k), 32'(ready1), 32'(r1_pat[k]));
            check($sformatf("hold valid1 c%0d", k), 32'(rsp_valid1), 32'(v1_pat[k]));
            check($sformatf("hold ready3 c%0d", k), 32'(ready3), 32'(r3_pat[k]));
            check($sformatf("hold valid3 c%0d", k), 32'(rsp_valid3), 32'(v3_pat[k]));
            if (k == 3) check("hold rdata3", rsp_rdata3, 32'h80223344);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);

        // rst pulsed while the READ_LAT=3 instance sits in LOAD.
        req_we    = 1'b0;
        req_memop = 3'b010;
        req_addr  = 32'h20;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid load ready3", 32'(ready3), 32'd0);
        check("rstmid load valid3", 32'(rsp_valid3), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid ready3 in rst", 32'(ready3), 32'd0);
        check("rstmid valid3 in rst", 32'(rsp_valid3), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid ready1 after", 32'(ready1), 32'd1);
        check("rstmid ready3 after", 32'(ready3), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstmid no rsp3 c%0d", k), 32'(rsp_valid3), 32'd0);
            @(negedge clk);
        end
        txn("lw20r", 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0);

        // Address beyond DEPTH*4: error with the bounds check, alias to word 0 without.
        txn("sw0",   1'b1, 3'b010, 32'h0, 32'h01234567, 32'h0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        txn("sw1000", 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1);
        txn("lw0",    1'b0, 3'b010, 32'h0, 32'h0, 32'h01234567, 1'b0);
`else
        txn("sw1000", 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("lw0",    1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
